// File: rtl/alu_reservation_station.sv
// ALU/branch reservation station: holds dispatched uops until both operands are
// available (snooping its own result and the LSB result), then issues one per cycle.
module alu_reservation_station #(
  parameter int ROB_BITS = 4,
  parameter int RS_SIZE  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [3:0]          in_op,
  input  logic [ROB_BITS-1:0] in_rob_id,
  input  logic [31:0]         in_vj,
  input  logic [31:0]         in_vk,
  input  logic                in_j_ready,
  input  logic                in_k_ready,
  input  logic [ROB_BITS-1:0] in_qj,
  input  logic [ROB_BITS-1:0] in_qk,
  input  logic                in_pred,
  output logic                full,
  input  logic                lsb_ready,
  input  logic [ROB_BITS-1:0] lsb_rob_id,
  input  logic [31:0]         lsb_value,
  output logic                out_ready,
  output logic [ROB_BITS-1:0] out_rob_id,
  output logic [31:0]         out_value
);
  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
  } op_e;

  typedef struct packed {
    logic                vld;
    logic [3:0]          op;
    logic [ROB_BITS-1:0] rob;
    logic [31:0]         vj;
    logic [31:0]         vk;
    logic                jr;
    logic                kr;
    logic [ROB_BITS-1:0] qj;
    logic [ROB_BITS-1:0] qk;
    logic                pred;
  } ent_t;

  ent_t [RS_SIZE-1:0]  ent_q, ent_d;
  logic                out_ready_q, out_ready_d;
  logic [ROB_BITS-1:0] out_rob_id_q, out_rob_id_d;
  logic [31:0]         out_value_q, out_value_d;

  logic [IW-1:0] free_idx, sel_idx;
  logic          free_found, sel_found;

  // Operand capture from the two result buses; the LSB takes priority on a tie.
  function automatic logic [32:0] wake(input logic r, input logic [ROB_BITS-1:0] q,
                                       input logic [31:0] v);
    wake = {r, v};
    if (!r) begin
      if (lsb_ready && lsb_rob_id == q)
        wake = {1'b1, lsb_value};
      else if (out_ready_q && out_rob_id_q == q)
        wake = {1'b1, out_value_q};
    end
  endfunction

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic pred);
    logic taken;
    taken = 1'b0;
    alu   = '0;
    case (op_e'(op))
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_SLL:  alu = a << b[4:0];
      OP_SRL:  alu = a >> b[4:0];
      OP_SRA:  alu = $unsigned($signed(a) >>> b[4:0]);
      OP_SLT:  alu = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: alu = {31'b0, a < b};
      default: begin
        case (op_e'(op))
          OP_BEQ:  taken = (a == b);
          OP_BNE:  taken = (a != b);
          OP_BLT:  taken = ($signed(a) < $signed(b));
          OP_BGE:  taken = ($signed(a) >= $signed(b));
          OP_BLTU: taken = (a < b);
          default: taken = (a >= b);
        endcase
        // bit0 clear tells the ROB the prediction was wrong
        alu = {31'b0, taken == pred};
      end
    endcase
  endfunction

  // Descending scan so the lowest matching index wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!ent_q[i].vld) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (ent_q[i].vld && ent_q[i].jr && ent_q[i].kr) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign full = ~free_found;

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ent_q[i].vld) begin
        {ent_d[i].jr, ent_d[i].vj} = wake(ent_q[i].jr, ent_q[i].qj, ent_q[i].vj);
        {ent_d[i].kr, ent_d[i].vk} = wake(ent_q[i].kr, ent_q[i].qk, ent_q[i].vk);
      end
    end
    if (sel_found) ent_d[sel_idx].vld = 1'b0;
    // free_idx comes from pre-edge state, so it never aliases the issuing entry
    if (in_valid && free_found) begin
      ent_d[free_idx].vld  = 1'b1;
      ent_d[free_idx].op   = in_op;
      ent_d[free_idx].rob  = in_rob_id;
      ent_d[free_idx].qj   = in_qj;
      ent_d[free_idx].qk   = in_qk;
      ent_d[free_idx].pred = in_pred;
      {ent_d[free_idx].jr, ent_d[free_idx].vj} = wake(in_j_ready, in_qj, in_vj);
      {ent_d[free_idx].kr, ent_d[free_idx].vk} = wake(in_k_ready, in_qk, in_vk);
    end
    if (clear) begin
      for (int i = 0; i < RS_SIZE; i++) ent_d[i].vld = 1'b0;
    end
  end

  always_comb begin
    out_ready_d  = sel_found && !clear;
    out_rob_id_d = out_rob_id_q;
    out_value_d  = out_value_q;
    if (sel_found && !clear) begin
      out_rob_id_d = ent_q[sel_idx].rob;
      out_value_d  = alu(ent_q[sel_idx].op, ent_q[sel_idx].vj, ent_q[sel_idx].vk,
                         ent_q[sel_idx].pred);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q        <= '0;
      out_ready_q  <= 1'b0;
      out_rob_id_q <= '0;
      out_value_q  <= '0;
    end else if (rdy) begin
      ent_q        <= ent_d;
      out_ready_q  <= out_ready_d;
      out_rob_id_q <= out_rob_id_d;
      out_value_q  <= out_value_d;
    end
  end

  assign out_ready  = out_ready_q;
  assign out_rob_id = out_rob_id_q;
  assign out_value  = out_value_q;
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Out-of-order issue buffer for integer ALU and branch-compare µops; sits between the decoder/dispatch stage and the reorder buffer.
- Holds dispatched µops until both operands are available, capturing operands from the common data bus (its own ALU result and the LSB result).
- Issues one ready µop per cycle to an internal single-cycle ALU and drives the registered result to the ROB via out_ready/out_rob_id/out_value (the ROB's rs_* inputs).

Parameters:
- ROB_BITS, 4, width of a ROB tag (ROB depth = 2^ROB_BITS).
- RS_SIZE, 8, number of station entries.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- rdy  input  1  global enable; when 0, all state holds.
- clear  input  1  mispredict flush from the ROB.
- in_valid  input  1  dispatch request.
- in_op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
- in_rob_id  input  ROB_BITS  destination ROB tag.
- in_vj, in_vk  input  32  operand values, valid when the matching ready bit is 1.
- in_j_ready, in_k_ready  input  1  operand already available.
- in_qj, in_qk  input  ROB_BITS  producer tag when not ready.
- in_pred  input  1  predicted-taken bit (branches only).
- full  output  1  no free entry.
- lsb_ready  input  1  LSB broadcast valid.
- lsb_rob_id  input  ROB_BITS  LSB broadcast tag.
- lsb_value  input  32  LSB broadcast value.
- out_ready  output  1  result valid (one-cycle pulse).
- out_rob_id  output  ROB_BITS  result tag.
- out_value  output  32  result value.

Behaviour:
- Reset (rst=1, async): all entries invalid; out_ready=0, out_rob_id=0, out_value=0.
- full is combinational: 1 iff all RS_SIZE entries are valid.
- rdy=0: no dispatch, wakeup, issue or output change. out_ready keeps its value; the ROB gates with rdy.
- Flush (clear=1 && rdy=1, on clk edge): all entries invalidated, out_ready<=0. Dispatch, issue and wakeup in that cycle are discarded.
- Dispatch: on an edge with rdy && in_valid && !full, the lowest-index free entry is written. in_valid while full is ignored and no entry changes; the upstream stage must not assert it.
- Dispatch bypass: if an operand is not ready and its in_q matches a broadcast in the same cycle, it is written as ready with the broadcast value. Broadcast sources are (out_ready, out_rob_id, out_value) and (lsb_ready, lsb_rob_id, lsb_value); the LSB wins if both match.
- Wakeup: every valid entry with a not-ready operand whose tag matches an active broadcast captures the value and sets ready on that edge. The same priority as dispatch bypass applies.
- Select: combinationally, the lowest-index valid entry with both operands ready, evaluated on register state (no same-cycle wakeup-to-issue).
- Issue: on the edge, the selected entry is freed. out_ready<=1, out_rob_id<=tag, out_value<=ALU(op, vj, vk).
  - If nothing is selected, out_ready<=0.
  - An entry freed on an edge is not reusable by a dispatch on the same edge; full reflects pre-edge state.
- Latency: a µop dispatched with both operands ready on edge E0 produces out_ready=1 after edge E1. A woken operand adds one cycle after its capture edge.
- ALU rules:
  - Shifts use vk[4:0]; SRA is arithmetic.
  - SLT/SLTU return 0 or 1; all arithmetic wraps modulo 2^32.
  - Branch ops compute taken = cond(vj, vk); signed for BLT/BGE, unsigned for BLTU/BGEU.
  - Branch result out_value = {31'b0, taken == pred}; bit0=0 signals a mispredict to the ROB.
- Tag wrap-around is irrelevant here: tags are compared for equality only.

Test Plan:
- Ready dispatch: ADD vj=5, vk=7, rob_id=3, both ready at E0 -> out_ready=1, out_rob_id=3, out_value=12 after E1; out_ready=0 after E2.
- Wakeup: SUB with qj=2 not ready, vk=1 ready, rob_id=4; two cycles later lsb_ready, lsb_rob_id=2, lsb_value=10 -> out_value=9, rob_id=4 one cycle after capture.
- Full/ordering: 8 dispatches with unresolved qj=9 -> full=1 and a 9th in_valid is ignored. Broadcast tag 9 value 1 -> entries retire in index order, one per cycle, over 8 cycles; full=0 after the first issue edge.
- Branch: BLT vj=0xFFFFFFFF, vk=1, pred=0 -> taken=1, out_value=0. BLTU with the same operands and pred=0 -> out_value=1.
- Bypass priority: dispatch with qj=5 while out_rob_id=5 (value 20) and lsb_rob_id=5 (value 30) are both broadcast -> operand captured as 30.
- Flush/rdy/reset: 3 pending entries, then clear && rdy -> full=0, no further out_ready. With rdy=0 for 4 cycles, outputs hold. Async rst mid-issue -> out_ready=0 immediately.
